// File: rtl/trig_lut_loader.sv
// trig_lut_loader: serially loads 32-entry truth tables into SRLC32E trigger LUTs.
// A request (cfg_sel, cfg_data) is captured on the handshake edge, then shifted
// MSB first into the selected SRL over 32 cycles. lut_valid[n] is low for the
// whole time LUT n holds partial contents.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request; cfg_ready high (outside reset)
// SHIFT  | srl_ce[sel] high, one truth-table bit per cycle, 32 cycles
// FINISH | one cycle: done pulses, lut_valid[sel] sets
module trig_lut_loader #(
    parameter int NUM_LUTS = 4,
    parameter int SEL_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [SEL_BITS-1:0] cfg_sel,
    input  logic [31:0]         cfg_data,
    output logic [NUM_LUTS-1:0] srl_ce,
    output logic                srl_din,
    output logic [NUM_LUTS-1:0] lut_valid,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Select values at or above this limit have no LUT behind them.
    localparam logic [SEL_BITS:0] LUT_LIMIT = (SEL_BITS+1)'(NUM_LUTS);

    state_t              state, state_nxt;
    logic [4:0]          cnt, cnt_nxt;
    logic [SEL_BITS-1:0] sel_q, sel_nxt;
    logic [31:0]         data_q, data_nxt;
    logic [NUM_LUTS-1:0] ce_nxt, lv_nxt;
    logic                din_nxt, done_nxt, err_nxt;
    logic                accept, sel_ok;

    function automatic logic [NUM_LUTS-1:0] decode(input logic [SEL_BITS-1:0] s);
        logic [NUM_LUTS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            if (s == SEL_BITS'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

    assign busy      = (state != IDLE);
    assign cfg_ready = !busy && !rst;
    assign accept    = cfg_valid && cfg_ready;
    assign sel_ok    = ({1'b0, cfg_sel} < LUT_LIMIT);

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_q;
        data_nxt  = data_q;
        ce_nxt    = '0;
        din_nxt   = 1'b0;
        lv_nxt    = lut_valid;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        // First bit goes out in the cycle right after accept;
                        // the remainder waits in data_q, MSB-aligned.
                        state_nxt = SHIFT;
                        cnt_nxt   = 5'd0;
                        sel_nxt   = cfg_sel;
                        data_nxt  = {cfg_data[30:0], 1'b0};
                        ce_nxt    = decode(cfg_sel);
                        din_nxt   = cfg_data[31];
                        lv_nxt    = lut_valid & ~decode(cfg_sel);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt == 5'd31) begin
                    state_nxt = FINISH;
                    done_nxt  = 1'b1;
                    lv_nxt    = lut_valid | decode(sel_q);
                end else begin
                    cnt_nxt  = cnt + 5'd1;
                    ce_nxt   = decode(sel_q);
                    din_nxt  = data_q[31];
                    data_nxt = {data_q[30:0], 1'b0};
                end
            end
            FINISH: begin
                state_nxt = IDLE;
                cnt_nxt   = 5'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 5'd0;
            end
        endcase
    end

    // State, counter, captured request and registered outputs; reset drops srl_ce at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            sel_q     <= '0;
            data_q    <= 32'd0;
            srl_ce    <= '0;
            srl_din   <= 1'b0;
            lut_valid <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sel_q     <= sel_nxt;
            data_q    <= data_nxt;
            srl_ce    <= ce_nxt;
            srl_din   <= din_nxt;
            lut_valid <= lv_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_trig_lut_loader.sv
// Directed bench for trig_lut_loader: a 4-LUT instance with SRLC32E models on
// every CE output, and a 3-LUT instance for the out-of-range select case.
module tb_trig_lut_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cfg_valid, cfg_ready, srl_din, busy, done, err;
    logic [1:0]  cfg_sel;
    logic [31:0] cfg_data;
    logic [3:0]  srl_ce, lut_valid;

    logic        cfg_valid3, cfg_ready3, srl_din3, busy3, done3, err3;
    logic [1:0]  cfg_sel3;
    logic [31:0] cfg_data3;
    logic [2:0]  srl_ce3, lut_valid3;

    logic [31:0] srl [4];

    int total = 0;
    int fails = 0;
    int overlap = 0;
    int din_bad = 0;
    int err_seen = 0;

    trig_lut_loader #(.NUM_LUTS(4), .SEL_BITS(2)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .srl_ce(srl_ce), .srl_din(srl_din),
        .lut_valid(lut_valid), .busy(busy), .done(done), .err(err)
    );

    trig_lut_loader #(.NUM_LUTS(3), .SEL_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
        .cfg_sel(cfg_sel3), .cfg_data(cfg_data3), .srl_ce(srl_ce3), .srl_din(srl_din3),
        .lut_valid(lut_valid3), .busy(busy3), .done(done3), .err(err3)
    );

    always #5 clk = ~clk;

    // SRLC32E models: shift in D on every clock with CE, address i reads bit i.
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (srl_ce[n]) srl[n] <= {srl[n][30:0], srl_din};
        end
    end

    // Background monitors on the 4-LUT instance.
    always @(negedge clk) begin
        if ($countones(srl_ce) > 1) overlap++;
        if (srl_ce == 4'b0000 && srl_din !== 1'b0) din_bad++;
        if (err === 1'b1) err_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request; returns at the negedge of shift cycle 0.
    task automatic do_accept(input logic [1:0] sel, input logic [31:0] data);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_data  = data;
        chk("ready_before_accept", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Called at the negedge of shift cycle 0; returns at the first IDLE negedge.
    task automatic run_shift(input logic [1:0] sel, input logic [31:0] exp);
        logic [31:0] stream;
        int          ce_good;
        chk("lut_valid_cleared", lut_valid[sel], 0);
        chk("busy_in_shift", busy, 1);
        chk("ready_in_shift", cfg_ready, 0);
        stream  = 32'd0;
        ce_good = 0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            stream = {stream[30:0], srl_din};
            if (srl_ce === (4'b0001 << sel)) ce_good++;
        end
        @(negedge clk);
        chk("finish_done", done, 1);
        chk("finish_ce_off", srl_ce, 0);
        chk("finish_lut_valid", lut_valid[sel], 1);
        chk("finish_busy", busy, 1);
        @(negedge clk);
        chk("idle_done_low", done, 0);
        chk("idle_busy_low", busy, 0);
        chk("idle_ready", cfg_ready, 1);
        chk("stream", stream, exp);
        chk("ce_cycles", ce_good, 32);
        chk("srl_contents", srl[sel], exp);
    endtask

    initial begin
        cfg_valid  = 1'b0;
        cfg_sel    = 2'd0;
        cfg_data   = 32'd0;
        cfg_valid3 = 1'b0;
        cfg_sel3   = 2'd0;
        cfg_data3  = 32'd0;

        // Reset state while rst is high.
        repeat (2) @(negedge clk);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ce", srl_ce, 0);
        chk("rst_din", srl_din, 0);
        chk("rst_lut_valid", lut_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready3", cfg_ready3, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", cfg_ready, 1);
        chk("ready3_after_rst", cfg_ready3, 1);

        // Single load into LUT 1.
        do_accept(2'd1, 32'h0000_AAAA);
        run_shift(2'd1, 32'h0000_AAAA);
        chk("single_lut_valid", lut_valid, 4'b0010);
        chk("srl1_addr0", srl[1][0], 0);
        chk("srl1_addr1", srl[1][1], 1);
        chk("srl1_addr16", srl[1][16], 0);

        // 3-LUT instance: valid load to LUT 2, then out-of-range select 3.
        @(negedge clk);
        cfg_valid3 = 1'b1;
        cfg_sel3   = 2'd2;
        cfg_data3  = 32'h5555_5555;
        @(negedge clk);
        cfg_valid3 = 1'b0;
        repeat (40) @(negedge clk);
        chk("dut3_lut_valid_pre", lut_valid3, 3'b100);
        cfg_valid3 = 1'b1;
        cfg_sel3   = 2'd3;
        cfg_data3  = 32'hFFFF_FFFF;
        chk("oor_ready_before", cfg_ready3, 1);
        @(negedge clk);
        cfg_valid3 = 1'b0;
        chk("oor_err_pulse", err3, 1);
        chk("oor_ce", srl_ce3, 0);
        chk("oor_busy", busy3, 0);
        chk("oor_lut_valid", lut_valid3, 3'b100);
        @(negedge clk);
        chk("oor_err_clear", err3, 0);
        chk("oor_ready_after", cfg_ready3, 1);
        chk("oor_ce_after", srl_ce3, 0);

        // Back-to-back loads with cfg_valid held: sel 0 then sel 2, 34 cycles apart.
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_lut_valid", lut_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_sel   = 2'd0;
        cfg_data  = 32'hC3A5_0F81;
        chk("b2b_ready_first", cfg_ready, 1);
        @(negedge clk);
        cfg_sel   = 2'd2;
        cfg_data  = 32'h1357_9BDF;
        run_shift(2'd0, 32'hC3A5_0F81);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("b2b_second_start", srl_ce, 4'b0100);
        run_shift(2'd2, 32'h1357_9BDF);
        chk("b2b_lut_valid", lut_valid, 4'b0101);
        chk("b2b_no_overlap", overlap, 0);

        // Reset during shift cycle 10 of a load to LUT 0.
        do_accept(2'd0, 32'h1234_5678);
        repeat (10) @(negedge clk);
        chk("mid_shift_ce", srl_ce, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ce", srl_ce, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_lut_valid", lut_valid, 0);
        chk("async_rst_ready", cfg_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ce", srl_ce, 0);
        chk("post_rst_lut0", lut_valid[0], 0);
        chk("post_rst_ready", cfg_ready, 1);

        // Full reload of LUT 0, with cfg_data disturbed during the shift.
        do_accept(2'd0, 32'h1234_5678);
        cfg_data = 32'hEDCB_A987;
        run_shift(2'd0, 32'h1234_5678);
        chk("reload0_lut_valid", lut_valid, 4'b0001);

        // Reload of an already valid LUT 2.
        do_accept(2'd2, 32'hDEAD_BEEF);
        run_shift(2'd2, 32'hDEAD_BEEF);
        chk("lut2_first_valid", lut_valid, 4'b0101);
        do_accept(2'd2, 32'hFFFF_0000);
        run_shift(2'd2, 32'hFFFF_0000);
        chk("lut2_reload_valid", lut_valid, 4'b0101);
        chk("lut0_untouched", srl[0], 32'h1234_5678);

        chk("no_ce_overlap", overlap, 0);
        chk("din_zero_when_idle", din_bad, 0);
        chk("no_err_in_range", err_seen, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
